// File: rtl/segre_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : segre_cache_controller
// Purpose  : Tag store and miss-sequencing FSM for a direct-mapped, write-back,
//            write-allocate data cache, with saturating hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module segre_cache_controller #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16,
    parameter int NUM_LINES  = 16
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              ready_o,
    output logic              dc_wr_into_word_o,
    output logic              dc_wr_line_o,
    output logic [ADDR_W-1:0] dc_addr_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int C_OFF_W = $clog2(LINE_BYTES);
    localparam int C_IDX_W = $clog2(NUM_LINES);
    localparam int C_TAG_L = C_OFF_W + C_IDX_W;
    localparam int C_TAG_W = ADDR_W - C_TAG_L;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_LINES-1:0]     valid_q;
    logic [NUM_LINES-1:0]     dirty_q;
    logic [C_TAG_W-1:0]       tag_q [NUM_LINES];
    logic [ADDR_W-1:0]        maddr_q, maddr_d;
    logic [31:0]              hit_cnt_q, hit_cnt_d;
    logic [31:0]              miss_cnt_q, miss_cnt_d;

    logic [ADDR_W-1:0]        w_cur_addr;
    logic [C_TAG_W-1:0]       w_tag;
    logic [C_IDX_W-1:0]       w_idx;
    logic                     w_hit;
    logic                     w_ready;
    logic                     w_wr_word;
    logic                     w_wr_line;
    logic                     w_mem_req;
    logic                     w_mem_we;
    logic [ADDR_W-1:0]        w_mem_addr;
    logic                     w_set_dirty;
    logic                     w_clr_dirty;
    logic                     w_install;

    // While a miss is in flight the latched miss address drives the lookup, so
    // the transaction completes correctly even if the core withdraws req_i.
    assign w_cur_addr = (state_q == ST_IDLE) ? addr_i : maddr_q;
    assign w_tag      = w_cur_addr[ADDR_W-1:C_TAG_L];
    assign w_idx      = w_cur_addr[C_TAG_L-1:C_OFF_W];
    assign w_hit      = valid_q[w_idx] && (tag_q[w_idx] == w_tag);

    always_comb begin
        state_d     = state_q;
        maddr_d     = maddr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        w_ready     = 1'b0;
        w_wr_word   = 1'b0;
        w_wr_line   = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_set_dirty = 1'b0;
        w_clr_dirty = 1'b0;
        w_install   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (w_hit) begin
                        w_ready     = 1'b1;
                        w_wr_word   = we_i;
                        w_set_dirty = we_i;
                        if (hit_cnt_q != 32'hFFFF_FFFF) begin
                            hit_cnt_d = hit_cnt_q + 32'd1;
                        end
                    end else begin
                        maddr_d = addr_i;
                        if (miss_cnt_q != 32'hFFFF_FFFF) begin
                            miss_cnt_d = miss_cnt_q + 32'd1;
                        end
                        if (valid_q[w_idx] && dirty_q[w_idx]) begin
                            state_d = ST_WRITEBACK;
                        end else begin
                            state_d = ST_REFILL;
                        end
                    end
                end
            end
            ST_WRITEBACK: begin
                w_mem_req  = 1'b1;
                w_mem_we   = 1'b1;
                w_mem_addr = {tag_q[w_idx], w_idx, {C_OFF_W{1'b0}}};
                if (mem_ready_i) begin
                    w_clr_dirty = 1'b1;
                    state_d     = ST_REFILL;
                end
            end
            ST_REFILL: begin
                w_mem_req  = 1'b1;
                w_mem_addr = {w_tag, w_idx, {C_OFF_W{1'b0}}};
                if (mem_ready_i) begin
                    w_wr_line = 1'b1;
                    w_install = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q    <= ST_IDLE;
            maddr_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            maddr_q    <= maddr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (w_set_dirty) begin
                dirty_q[w_idx] <= 1'b1;
            end
            if (w_clr_dirty) begin
                dirty_q[w_idx] <= 1'b0;
            end
            if (w_install) begin
                valid_q[w_idx] <= 1'b1;
                dirty_q[w_idx] <= 1'b0;
                tag_q[w_idx]   <= w_tag;
            end
        end
    end

    // Control outputs are gated by reset so they collapse without waiting for a clock.
    assign ready_o           = rsn_i & w_ready;
    assign dc_wr_into_word_o = rsn_i & w_wr_word;
    assign dc_wr_line_o      = rsn_i & w_wr_line;
    assign mem_req_o         = rsn_i & w_mem_req;
    assign mem_we_o          = rsn_i & w_mem_we;
    assign mem_addr_o        = rsn_i ? w_mem_addr : '0;
    assign dc_addr_o         = w_cur_addr;
    assign hit_cnt_o         = hit_cnt_q;
    assign miss_cnt_o        = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_segre_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_segre_cache_controller
// Purpose  : Directed bench for segre_cache_controller with a latency-programmable
//            memory responder and a scoreboard of expected memory operations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segre_cache_controller;

    logic        clk_i;
    logic        rsn_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic        ready_o;
    logic        dc_wr_into_word_o;
    logic        dc_wr_line_o;
    logic [31:0] dc_addr_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    int          tests;
    int          fails;
    int          mem_lat;
    int          wait_cnt;
    logic [31:0] exp_hit;
    logic [31:0] exp_miss;
    logic [32:0] sb_q [$];

    segre_cache_controller #(
        .ADDR_W(32), .LINE_BYTES(16), .NUM_LINES(16)
    ) dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .ready_o(ready_o), .dc_wr_into_word_o(dc_wr_into_word_o),
        .dc_wr_line_o(dc_wr_line_o), .dc_addr_o(dc_addr_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_ready_i(mem_ready_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    // Memory model: completes the current op on the mem_lat-th cycle it is requested.
    initial begin
        mem_ready_i = 1'b0;
        wait_cnt    = 0;
        forever begin
            @(negedge clk_i);
            mem_ready_i = 1'b0;
            if (mem_req_o && rsn_i) begin
                if (wait_cnt >= mem_lat - 1) begin
                    mem_ready_i = 1'b1;
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard and per-cycle invariants.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk_i);
            #2;
            if (rsn_i) begin
                chk("ready_vs_memreq", {31'd0, ready_o & mem_req_o}, 32'd0);
                chk("wr_line_strobe", {31'd0, dc_wr_line_o},
                    {31'd0, mem_req_o & ~mem_we_o & mem_ready_i});
                chk("strobe_excl", {31'd0, dc_wr_line_o & dc_wr_into_word_o}, 32'd0);
                if (mem_req_o && mem_ready_i) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_op", mem_addr_o, 32'hDEAD_BEEF);
                    end else begin
                        e = sb_q.pop_front();
                        chk("mem_we", {31'd0, mem_we_o}, {31'd0, e[32]});
                        chk("mem_addr", mem_addr_o, e[31:0]);
                    end
                end
            end
        end
    end

    task automatic push_mem(input logic we, input logic [31:0] a);
        sb_q.push_back({we, a});
    endtask

    // One access held until ready_o; exp_cyc = edges expected before completion.
    task automatic access(input logic we, input logic [31:0] a, input int exp_cyc);
        int cyc;
        bit done;
        cyc  = 0;
        done = 0;
        req_i  = 1'b1;
        we_i   = we;
        addr_i = a;
        while (!done) begin
            #1;
            if (ready_o) begin
                done = 1;
            end else if (cyc >= 200) begin
                chk("access_timeout", 32'd0, 32'd1);
                done = 1;
            end else begin
                @(negedge clk_i);
                cyc++;
            end
        end
        chk("hit_wr_word", {31'd0, dc_wr_into_word_o}, {31'd0, we});
        chk("hit_no_memreq", {31'd0, mem_req_o}, 32'd0);
        chk("hit_dc_addr", dc_addr_o, a);
        chk("access_latency", cyc, exp_cyc);
        if (exp_cyc > 0 && exp_miss != 32'hFFFF_FFFF) exp_miss++;
        if (exp_hit != 32'hFFFF_FFFF) exp_hit++;
        @(negedge clk_i);
        req_i = 1'b0;
        #1;
        chk("hit_cnt", hit_cnt_o, exp_hit);
        chk("miss_cnt", miss_cnt_o, exp_miss);
        chk("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        mem_lat  = 3;
        exp_hit  = '0;
        exp_miss = '0;
        rsn_i    = 1'b0;
        req_i    = 1'b0;
        we_i     = 1'b0;
        addr_i   = 32'h0000_0104;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_memreq", {31'd0, mem_req_o}, 32'd0);
        chk("rst_hit_cnt", hit_cnt_o, 32'd0);
        chk("rst_miss_cnt", miss_cnt_o, 32'd0);
        chk("rst_dc_addr", dc_addr_o, 32'h0000_0104);
        @(negedge clk_i);
        rsn_i = 1'b1;
        @(negedge clk_i);

        // Cold load miss, then replay hit
        push_mem(1'b0, 32'h0000_0100);
        access(1'b0, 32'h0000_0104, mem_lat + 1);

        // Load hit, store hit, then conflicting load forces writeback of dirty victim
        access(1'b0, 32'h0000_0104, 0);
        access(1'b1, 32'h0000_0104, 0);
        push_mem(1'b1, 32'h0000_0100);
        push_mem(1'b0, 32'h0000_0200);
        access(1'b0, 32'h0000_0204, 2 * mem_lat + 1);

        // Clean victims go straight to refill
        push_mem(1'b0, 32'h0000_0300);
        access(1'b0, 32'h0000_0300, mem_lat + 1);
        push_mem(1'b0, 32'h0000_0400);
        access(1'b0, 32'h0000_0400, mem_lat + 1);

        // Store hit marks the line dirty, visible as a writeback on the next conflict
        push_mem(1'b0, 32'h0000_0100);
        access(1'b0, 32'h0000_0108, mem_lat + 1);
        access(1'b1, 32'h0000_0108, 0);
        push_mem(1'b1, 32'h0000_0100);
        push_mem(1'b0, 32'h0000_0200);
        access(1'b0, 32'h0000_0208, 2 * mem_lat + 1);

        // Reset in the middle of a stalled refill
        mem_lat = 5;
        req_i   = 1'b1;
        we_i    = 1'b0;
        addr_i  = 32'h0000_0504;
        @(negedge clk_i);
        #1;
        chk("refill_memreq", {31'd0, mem_req_o}, 32'd1);
        chk("refill_memwe", {31'd0, mem_we_o}, 32'd0);
        chk("refill_addr", mem_addr_o, 32'h0000_0500);
        @(negedge clk_i);
        rsn_i = 1'b0;
        #1;
        chk("midrst_memreq", {31'd0, mem_req_o}, 32'd0);
        chk("midrst_ready", {31'd0, ready_o}, 32'd0);
        chk("midrst_wr_line", {31'd0, dc_wr_line_o}, 32'd0);
        chk("midrst_hit_cnt", hit_cnt_o, 32'd0);
        chk("midrst_miss_cnt", miss_cnt_o, 32'd0);
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        rsn_i    = 1'b1;
        exp_hit  = '0;
        exp_miss = '0;
        @(negedge clk_i);
        push_mem(1'b0, 32'h0000_0200);
        access(1'b0, 32'h0000_0204, mem_lat + 1);

        // Request withdrawn during refill: line still installed
        mem_lat = 3;
        push_mem(1'b0, 32'h0000_0600);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h0000_0604;
        @(negedge clk_i);
        req_i = 1'b0;
        exp_miss++;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk_i);
        #3;
        chk("withdrawn_refill_done", sb_q.size(), 0);
        @(negedge clk_i);
        access(1'b0, 32'h0000_0604, 0);

        // Hit counter saturation
        force dut.hit_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.hit_cnt_q;
        #1;
        exp_hit = 32'hFFFF_FFFE;
        chk("hit_cnt_preload", hit_cnt_o, exp_hit);
        @(negedge clk_i);
        for (int k = 0; k < 3; k++) access(1'b0, 32'h0000_0604, 0);
        chk("hit_cnt_saturated", hit_cnt_o, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
